// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_bank block: FSM state encoding and
// the byte-enable merge used by the storage write port.
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } sram_state_t;

    // Widest word the merge helper supports; callers zero-extend into it.
    localparam int unsigned MAX_DATA_W = 512;
    localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

    // Replace byte i of old_w with byte i of new_w wherever be[i] is set.
    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(MAX_BE_W); i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_bank_if.sv
// Request/response bus of the sram_bank: requester drives the master side,
// the bank implements the slave side.
interface sram_bank_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_W / 8
);
    logic              cs;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              clr;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] data_out;
    logic              busy;

    modport master (
        output cs, we, be, addr, data_in, clr,
        input  req_ready, rsp_valid, rsp_err, data_out, busy
    );

    modport slave (
        input  cs, we, be, addr, data_in, clr,
        output req_ready, rsp_valid, rsp_err, data_out, busy
    );
endinterface

// File: rtl/sram_array.sv
// Storage for sram_bank: one byte-enabled write port and one registered read
// port. Addresses are assumed in range; the bank filters out-of-range access.
module sram_array
    import sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [BE_W-1:0]   wr_be_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] wr_word_d;

    assign wr_word_d = DATA_W'(be_merge(MAX_DATA_W'(mem_q[wr_addr_i]),
                                        MAX_DATA_W'(wr_data_i),
                                        MAX_BE_W'(wr_be_i)));

    // Write the merged word and capture read data; the read register holds
    // its value between reads.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_word_d;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/sram_bank.sv
// Single-port SRAM bank: clear sequencer FSM, address range check and
// request/response handshake around the sram_array storage.
module sram_bank
    import sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic        clk,
    input  logic        rst_n,
    sram_bank_if.slave  bus
);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    sram_state_t       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              req_ready_q, busy_q;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rd_zero_q, rd_zero_d;

    logic              in_range;
    logic              arr_wr_en, arr_rd_en;
    logic [BE_W-1:0]   arr_be;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rd_data;

    assign in_range = ({1'b0, bus.addr} < DEPTH_L);

    // Next state, clear sweep, request decode and response flags.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rd_zero_d   = rd_zero_q;
        arr_wr_en   = 1'b0;
        arr_rd_en   = 1'b0;
        arr_be      = '1;
        arr_waddr   = ptr_q;
        arr_wdata   = '0;
        case (state_q)
            CLEAR: begin
                arr_wr_en = 1'b1;
                if (ptr_q == LAST_PTR) begin
                    ptr_d   = '0;
                    state_d = IDLE;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (bus.cs && req_ready_q) begin
                    if (bus.we) begin
                        arr_wr_en = in_range;
                        arr_be    = bus.be;
                        arr_waddr = bus.addr;
                        arr_wdata = bus.data_in;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = !in_range;
                        rd_zero_d   = !in_range;
                        arr_rd_en   = in_range;
                    end
                end
                // A coincident request has already been decoded above.
                if (bus.clr) state_d = CLEAR;
            end
            default: state_d = CLEAR;
        endcase
        // Reset freezes the array so a mid-sweep reset leaves no stray write.
        if (!rst_n) begin
            arr_wr_en = 1'b0;
            arr_rd_en = 1'b0;
        end
    end

    // Control and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            ptr_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_zero_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            req_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d == CLEAR);
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rd_zero_q   <= rd_zero_d;
        end
    end

    sram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk       (clk),
        .wr_en_i   (arr_wr_en),
        .wr_be_i   (arr_be),
        .wr_addr_i (arr_waddr),
        .wr_data_i (arr_wdata),
        .rd_en_i   (arr_rd_en),
        .rd_addr_i (bus.addr),
        .rd_data_o (arr_rd_data)
    );

    // Zero is shown after reset and after an out-of-range read until the
    // next in-range read refreshes the array's read register.
    assign bus.data_out  = rd_zero_q ? '0 : arr_rd_data;
    assign bus.req_ready = req_ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
